// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// function-field codes, FSM state encoding and datapath operation select.
package ex_muldiv_unit_pkg;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_t;

endpackage

// File: rtl/ex_muldiv_unit_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// MUL: shift-add over {acc, low}, where low holds the shrinking multiplier
//      and fills up with product bits from the top.
// DIV: restoring step; acc is the partial remainder, low shifts the dividend
//      out of its top and quotient bits in at its bottom.
module md_step_datapath
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  md_op_t           op,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] low,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] low_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Select between a shift-add and a trial-subtract step for this cycle
    always_comb begin
        sum      = acc + {1'b0, operand};
        shifted  = {acc[WIDTH-1:0], low[WIDTH-1]};
        diff     = shifted - {1'b0, operand};
        acc_next = '0;
        low_next = '0;
        if (op == OP_MUL) begin
            if (low[0]) begin
                acc_next = {1'b0, sum[WIDTH:1]};
                low_next = {sum[0], low[WIDTH-1:1]};
            end else begin
                acc_next = {1'b0, acc[WIDTH:1]};
                low_next = {acc[0], low[WIDTH-1:1]};
            end
        end else begin
            if (diff[WIDTH]) begin
                acc_next = shifted;
                low_next = {low[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = diff;
                low_next = {low[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative unsigned MULTU/DIVU unit with HI/LO registers and
// MFHI/MFLO read port. Holds the front end while a dependent op waits.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mf_valid,
    output logic [WIDTH-1:0] mf_result
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] low_next;
    md_op_t           op;

    logic is_mfhi;
    logic is_mflo;
    logic is_multu;
    logic is_divu;
    logic is_md;
    logic is_mf;

    assign is_mfhi  = ex_valid & (funct == FN_MFHI);
    assign is_mflo  = ex_valid & (funct == FN_MFLO);
    assign is_multu = ex_valid & (funct == FN_MULTU);
    assign is_divu  = ex_valid & (funct == FN_DIVU);
    assign is_md    = is_multu | is_divu;
    assign is_mf    = is_mfhi | is_mflo;

    assign op        = (state == ST_DIV) ? OP_DIV : OP_MUL;
    assign busy      = (state != ST_IDLE);
    assign stall     = busy & (is_md | is_mf);
    assign mf_valid  = is_mf & ~stall;
    assign mf_result = mf_valid ? (is_mfhi ? hi : lo) : '0;

    md_step_datapath #(
        .WIDTH    (WIDTH)
    ) u_step (
        .op       (op),
        .acc      (acc),
        .low      (low),
        .operand  (operand),
        .acc_next (acc_next),
        .low_next (low_next)
    );

    // FSM: accept an op in IDLE, iterate WIDTH steps, then publish HI/LO
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            acc     <= '0;
            low     <= '0;
            operand <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_multu) begin
                        acc     <= '0;
                        low     <= rt_val;
                        operand <= rs_val;
                        cnt     <= '0;
                        state   <= ST_MUL;
                    end else if (is_divu) begin
                        if (rt_val != '0) begin
                            acc     <= '0;
                            low     <= rs_val;
                            operand <= rt_val;
                            cnt     <= '0;
                            state   <= ST_DIV;
                        end else begin
                            hi <= rs_val;
                            lo <= '1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc <= acc_next;
                    low <= low_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        hi    <= acc_next[WIDTH-1:0];
                        lo    <= low_next;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit. A cycle-level reference keeps
// HI/LO as plain arithmetic results and the busy window as a countdown.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    localparam int         W      = 32;
    localparam logic [5:0] FN_ADD = 6'h20;

    logic         clk = 1'b0;
    logic         reset;
    logic         ex_valid;
    logic [5:0]   funct;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         stall;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         mf_valid;
    logic [W-1:0] mf_result;

    int vectors = 0;
    int misses  = 0;

    int           m_left;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [W-1:0] m_phi;
    logic [W-1:0] m_plo;

    logic [3*W+2:0] exp_vec;
    logic [3*W+2:0] obs_vec;
    logic           exp_stall;

    assign obs_vec = {busy, stall, mf_valid, mf_result, hi, lo};

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ex_valid  (ex_valid),
        .funct     (funct),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .stall     (stall),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .mf_valid  (mf_valid),
        .mf_result (mf_result)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Present one cycle of inputs, then compute expected outputs and advance the reference
    task automatic drive(input logic v, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic rn);
        logic         md;
        logic         mf;
        logic         e_busy;
        logic         e_mfv;
        logic [W-1:0] e_mfr;
        logic [63:0]  prod;
        @(negedge clk);
        ex_valid = v;
        funct    = f;
        rs_val   = a;
        rt_val   = b;
        reset    = rn;
        #1;
        md        = v && (f == FN_MULTU || f == FN_DIVU);
        mf        = v && (f == FN_MFHI || f == FN_MFLO);
        e_busy    = (m_left > 0);
        exp_stall = e_busy && (md || mf);
        e_mfv     = mf && !exp_stall;
        e_mfr     = e_mfv ? ((f == FN_MFHI) ? m_hi : m_lo) : '0;
        exp_vec   = {e_busy, exp_stall, e_mfv, e_mfr, m_hi, m_lo};
        if (!rn) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (v && f == FN_MULTU) begin
            prod   = 64'(a) * 64'(b);
            m_phi  = prod[63:32];
            m_plo  = prod[31:0];
            m_left = W;
        end else if (v && f == FN_DIVU) begin
            if (b != 0) begin
                m_phi  = a % b;
                m_plo  = a / b;
                m_left = W;
            end else begin
                m_hi = a;
                m_lo = '1;
            end
        end
    endtask

    // Reset clears state and all outputs
    task automatic test_reset();
        drive(1'b0, 6'h0, '0, '0, 1'b0);
        drive(1'b0, 6'h0, '0, '0, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL reset_outputs: got %h, required %h", obs_vec, exp_vec);
        end
        vectors++;
        if ({busy, stall, mf_valid, hi, lo} !== '0) begin
            misses++;
            $display("[TB] FAIL reset_zero: got busy=%b stall=%b hi=%h lo=%h, required all 0", busy, stall, hi, lo);
        end
        drive(1'b1, FN_MFHI, '0, '0, 1'b1);
        vectors++;
        if (obs_vec !== exp_vec) begin
            misses++;
            $display("[TB] FAIL reset_mfhi: got %h, required %h", obs_vec, exp_vec);
        end
    endtask

    // MULTU carry into HI and exact busy window length
    task automatic test_multu();
        int busy_cnt = 0;
        drive(1'b1, FN_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b1);
        for (int i = 0; i < 34; i++) begin
            drive(1'b0, 6'h0, '0, '0, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                misses++;
                $display("[TB] FAIL multu_cycle%0d: got %h, required %h", i, obs_vec, exp_vec);
            end
            if (busy === 1'b1) busy_cnt++;
        end
        vectors++;
        if (busy_cnt != 32) begin
            misses++;
            $display("[TB] FAIL multu_busy_len: got %0d, required 32", busy_cnt);
        end
        vectors++;
        if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
            misses++;
            $display("[TB] FAIL multu_result: got hi=%h lo=%h, required hi=00000001 lo=fffffffe", hi, lo);
        end
    endtask

    // DIVU with remainder, and by-one of the largest dividend
    task automatic test_divu();
        drive(1'b1, FN_DIVU, 32'd100, 32'd7, 1'b1);
        for (int i = 0; i < 33; i++) begin
            drive(1'b0, 6'h0, '0, '0, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                misses++;
                $display("[TB] FAIL divu_cycle%0d: got %h, required %h", i, obs_vec, exp_vec);
            end
        end
        vectors++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            misses++;
            $display("[TB] FAIL divu_100_7: got hi=%0d lo=%0d, required hi=2 lo=14", hi, lo);
        end
        drive(1'b1, FN_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b1);
        for (int i = 0; i < 33; i++) drive(1'b0, 6'h0, '0, '0, 1'b1);
        vectors++;
        if (hi !== 32'h0 || lo !== 32'hFFFF_FFFF) begin
            misses++;
            $display("[TB] FAIL divu_by_one: got hi=%h lo=%h, required hi=00000000 lo=ffffffff", hi, lo);
        end
    endtask

    // Divide by zero writes immediately; bubbles with MD funct do nothing
    task automatic test_div_by_zero();
        drive(1'b1, FN_DIVU, 32'd5, 32'd0, 1'b1);
        drive(1'b0, FN_MULTU, 32'd9, 32'd9, 1'b1);
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin
            misses++;
            $display("[TB] FAIL div_zero: got busy=%b hi=%h lo=%h, required busy=0 hi=00000005 lo=ffffffff", busy, hi, lo);
        end
        drive(1'b0, FN_MFLO, '0, '0, 1'b1);
        vectors++;
        if (obs_vec !== exp_vec || busy !== 1'b0) begin
            misses++;
            $display("[TB] FAIL bubble_no_accept: got %h, required %h", obs_vec, exp_vec);
        end
    endtask

    // Dependent MFLO stalls for the whole op, then reads once
    task automatic test_mf_stall();
        int stall_cnt = 0;
        drive(1'b1, FN_MULTU, 32'd3, 32'd4, 1'b1);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, FN_MFLO, '0, '0, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                misses++;
                $display("[TB] FAIL mflo_cycle%0d: got %h, required %h", i, obs_vec, exp_vec);
            end
            if (stall === 1'b1) stall_cnt++;
            if (!exp_stall) break;
        end
        vectors++;
        if (stall_cnt != 32 || mf_valid !== 1'b1 || mf_result !== 32'd12) begin
            misses++;
            $display("[TB] FAIL mflo_read: got stalls=%0d mf_valid=%b mf_result=%0d, required 32/1/12", stall_cnt, mf_valid, mf_result);
        end
        drive(1'b0, 6'h0, '0, '0, 1'b1);
        vectors++;
        if (mf_valid !== 1'b0) begin
            misses++;
            $display("[TB] FAIL mflo_once: got mf_valid=%b, required 0", mf_valid);
        end
    endtask

    // Non-MD instruction passes while busy; MFHI waits
    task automatic test_non_md_pass();
        drive(1'b1, FN_MULTU, 32'd3, 32'd4, 1'b1);
        drive(1'b1, FN_ADD, 32'd1, 32'd1, 1'b1);
        vectors++;
        if (stall !== 1'b0 || busy !== 1'b1) begin
            misses++;
            $display("[TB] FAIL add_pass: got stall=%b busy=%b, required stall=0 busy=1", stall, busy);
        end
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, FN_MFHI, '0, '0, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                misses++;
                $display("[TB] FAIL mfhi_cycle%0d: got %h, required %h", i, obs_vec, exp_vec);
            end
            if (!exp_stall) break;
        end
        vectors++;
        if (mf_valid !== 1'b1 || mf_result !== 32'd0) begin
            misses++;
            $display("[TB] FAIL mfhi_read: got mf_valid=%b mf_result=%h, required 1/0", mf_valid, mf_result);
        end
    endtask

    // Reset mid-divide abandons the op; a re-issue still completes
    task automatic test_reset_abort();
        drive(1'b1, FN_DIVU, 32'd100, 32'd7, 1'b1);
        for (int i = 0; i < 9; i++) drive(1'b0, 6'h0, '0, '0, 1'b1);
        drive(1'b0, 6'h0, '0, '0, 1'b0);
        drive(1'b1, FN_MFHI, '0, '0, 1'b1);
        vectors++;
        if (obs_vec !== exp_vec || busy !== 1'b0 || stall !== 1'b0 || hi !== '0 || lo !== '0) begin
            misses++;
            $display("[TB] FAIL abort_state: got %h, required %h", obs_vec, exp_vec);
        end
        drive(1'b1, FN_DIVU, 32'd100, 32'd7, 1'b1);
        for (int i = 0; i < 33; i++) drive(1'b0, 6'h0, '0, '0, 1'b1);
        vectors++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            misses++;
            $display("[TB] FAIL abort_reissue: got hi=%0d lo=%0d, required hi=2 lo=14", hi, lo);
        end
    endtask

    // DIVU issued right behind MULTU is held until the first op retires
    task automatic test_back_to_back();
        logic [W-1:0] c;
        logic [W-1:0] d;
        c = $urandom;
        d = $urandom_range(1, 1000);
        drive(1'b1, FN_MULTU, $urandom, $urandom, 1'b1);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, FN_DIVU, c, d, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                misses++;
                $display("[TB] FAIL b2b_cycle%0d: got %h, required %h", i, obs_vec, exp_vec);
            end
            if (!exp_stall) break;
        end
        for (int i = 0; i < 33; i++) drive(1'b0, 6'h0, '0, '0, 1'b1);
        vectors++;
        if (hi !== c % d || lo !== c / d) begin
            misses++;
            $display("[TB] FAIL b2b_divu: got hi=%h lo=%h, required hi=%h lo=%h", hi, lo, c % d, c / d);
        end
    endtask

    // Random instruction stream with held stalls and occasional reset
    task automatic test_random();
        logic         v;
        logic [5:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         rn;
        for (int n = 0; n < 60; n++) begin
            v = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 5))
                0:       f = FN_MFHI;
                1:       f = FN_MFLO;
                2:       f = FN_MULTU;
                3:       f = FN_DIVU;
                4:       f = FN_ADD;
                default: f = 6'($urandom);
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
            for (int k = 0; k < 40; k++) begin
                rn = ($urandom_range(0, 79) != 0);
                drive(v, f, a, b, rn);
                vectors++;
                if (obs_vec !== exp_vec) begin
                    misses++;
                    $display("[TB] FAIL rand_n%0d_k%0d: got %h, required %h", n, k, obs_vec, exp_vec);
                end
                if (!exp_stall) break;
            end
            vectors++;
            if (exp_stall) begin
                misses++;
                $display("[TB] FAIL rand_hold_timeout: got stall=%b, required release within 40 cycles", stall);
            end
        end
        for (int i = 0; i < 34; i++) drive(1'b0, 6'h0, '0, '0, 1'b1);
    endtask

    // Run all scenarios in order and report
    initial begin
        reset    = 1'b0;
        ex_valid = 1'b0;
        funct    = '0;
        rs_val   = '0;
        rt_val   = '0;
        m_left   = 0;
        m_hi     = '0;
        m_lo     = '0;
        m_phi    = '0;
        m_plo    = '0;
        test_reset();
        test_multu();
        test_divu();
        test_div_by_zero();
        test_mf_stall();
        test_non_md_pass();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
